jk_cmd_gen: RTL and testbench
=============================

# jk_cmd_gen

Command front-end that drives the `j`/`k` inputs of the downstream JK flip-flop stage from three raw, asynchronous push-button lines: set, clear and toggle. Each line passes through a two-flop synchronizer and a stability-counter debouncer. The rising edge of each debounced level is decoded into a single-cycle registered `j`/`k` pulse that connects directly to the flip-flop's `j`/`k` ports, sharing its `clk`. A wrapping command counter is also provided for observation.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required before a debounced level changes; legal range ≥ 2.
- `CNT_W`, default 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- `clk`  in  1  single clock, rising edge; all state is in this domain.
- `rst`  in  1  reset, synchronous, active-low; sampled only on rising `clk`.
- `en`  in  1  command enable; synchronous to `clk`.
- `btn_set`  in  1  raw set request, asynchronous, active-high.
- `btn_clr`  in  1  raw clear request, asynchronous, active-high.
- `btn_tgl`  in  1  raw toggle request, asynchronous, active-high.
- `j`  out  1  registered J drive to the flip-flop stage; one-cycle pulse.
- `k`  out  1  registered K drive to the flip-flop stage; one-cycle pulse.
- `db_lvl`  out  3  debounced levels {tgl, clr, set}, registered.
- `cmd_cnt`  out  8  count of issued commands; wraps 255→0.

## Operation
- **Per-line datapath**, identical for set, clr and tgl:
  - `sync1 <= btn`, then `sync2 <= sync1`.
  - `cnt` and `db` are updated as follows:
    - if `sync2 == db`: `cnt <= 0`;
    - else if `cnt == DEBOUNCE_CYCLES-1`: `db <= sync2`, `cnt <= 0`;
    - else: `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `db`. Any return to equality clears `cnt`.
  - `evt` is a one-cycle signal asserted when `db` rises, i.e. when the registered previous value was 0 and `db` is now 1. A falling `db` produces no event.
- **Decode** is registered every cycle:
  - `j <= en & (set_evt | tgl_evt)`
  - `k <= en & (clr_evt | tgl_evt)`
  - Simultaneous set and clear events give `j=k=1`, which is a toggle under JK semantics. Any combination involving tgl also gives `j=k=1`.
- **`cmd_cnt`** increments by 1 on each cycle where the next `j|k` is 1, so it rises in the same cycle `j`/`k` pulse. It is 8-bit modulo.
- **`en` low:** events are discarded and are not queued. Synchronizers and debouncers keep running.
- **Reset** (`rst==0` at a clock edge): all synchronizer flops, `cnt`, `db`, the previous-`db` registers, `j`, `k`, `db_lvl` and `cmd_cnt` go to 0.
  - Reset asserted mid-debounce aborts the debounce with no pulse.
  - Reset asserted in the cycle a pulse would be registered suppresses that pulse.
  - A button still held when reset releases is debounced from zero and produces one command.

## Timing
- Outputs reset to `j=0`, `k=0`, `db_lvl=3'b000`, `cmd_cnt=0`.
- **Latency** from the first rising edge that samples `btn` high, with `btn` held stable, is counted at each register:
  - `sync1` rises at edge 1 and `sync2` at edge 2.
  - `db` rises at edge 2+DEBOUNCE_CYCLES.
  - `j`/`k` go high after edge 3+DEBOUNCE_CYCLES and stay high exactly one cycle. With the default this is edge 19.
- A held button issues exactly one command. Release and re-press each require a full debounce before the next command.
- Events on different lines separated by at least one cycle produce separate pulses, which may be back-to-back.
- `en` is sampled at the edge that registers `j`/`k`.

## Test plan
- **Reset values:** hold `rst=0` for 3 cycles with all buttons high. Require `j=k=0`, `cmd_cnt=0` and `db_lvl=0`. Release reset with `btn_set` held. Require `j=1`, `k=0` for exactly one cycle, 3+16 edges after release, and `cmd_cnt=1`.
- **Glitch rejection:** pulse `btn_clr` high for 10 cycles, then low, with the default parameter. Require no `k` pulse, `db_lvl[1]` stays 0 and `cmd_cnt` is unchanged.
- **Simultaneous set and clear:** assert `btn_set` and `btn_clr` at the same edge and hold for 40 cycles. Require a single cycle with `j=1`, `k=1`, `cmd_cnt` incremented by 1, and no further pulses while held.
- **Enable gating:** press `btn_tgl` with `en=0`, then set `en=1` while it is still held. Require no pulse and `db_lvl[2]=1`. Release, then press again. Require `j=k=1` once.
- **Counter wrap:** issue 256 separate set presses with `en=1`. Require `cmd_cnt` to read 0 after the 256th pulse, with exactly 256 `j` pulses and zero `k` pulses.
- **Reset mid-debounce:** hold `btn_tgl` for 10 cycles, then pull `rst` low for 1 cycle while still holding. Require no pulse before a full 3+16 cycles after reset release, then exactly one `j=k=1` pulse.

Source files
------------

// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen: debounced set/clear/toggle buttons decoded into single-cycle
// registered j/k pulses for a downstream JK flip-flop, plus a wrapping
// command counter for observation.
module jk_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_set,
  input  logic       btn_clr,
  input  logic       btn_tgl,
  output logic       j,
  output logic       k,
  output logic [2:0] db_lvl,
  output logic [7:0] cmd_cnt
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Line order everywhere is {tgl, clr, set}.
  logic [2:0]       w_btn;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_db;
  logic [2:0]       r_db_prev;
  logic [CNT_W-1:0] r_cnt [0:2];
  logic [2:0]       w_evt;
  logic             w_j_nxt;
  logic             w_k_nxt;
  logic             r_j;
  logic             r_k;
  logic [7:0]       r_cmd_cnt;

  assign w_btn = {btn_tgl, btn_clr, btn_set};

  // Two-flop synchronizer for the asynchronous button lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Stability-counter debouncer: db follows sync2 only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced level, used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db_prev <= '0;
    end else begin
      r_db_prev <= r_db;
    end
  end

  assign w_evt   = r_db & ~r_db_prev;
  assign w_j_nxt = en & (w_evt[0] | w_evt[2]);
  assign w_k_nxt = en & (w_evt[1] | w_evt[2]);

  // Registered j/k decode; the counter advances on the same edge so it
  // changes in the cycle the pulse is visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_j       <= 1'b0;
      r_k       <= 1'b0;
      r_cmd_cnt <= '0;
    end else begin
      r_j       <= w_j_nxt;
      r_k       <= w_k_nxt;
      r_cmd_cnt <= r_cmd_cnt + {7'd0, (w_j_nxt | w_k_nxt)};
    end
  end

  assign j       = r_j;
  assign k       = r_k;
  assign db_lvl  = r_db;
  assign cmd_cnt = r_cmd_cnt;

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Directed self-checking bench for jk_cmd_gen with default parameters.
module tb_jk_cmd_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       btn_set;
  logic       btn_clr;
  logic       btn_tgl;
  logic       j;
  logic       k;
  logic [2:0] db_lvl;
  logic [7:0] cmd_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse tallies sampled on the falling edge, away from the active edge.
  int j_pulses  = 0;
  int k_pulses  = 0;
  int jk_pulses = 0;

  jk_cmd_gen #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .btn_set (btn_set),
    .btn_clr (btn_clr),
    .btn_tgl (btn_tgl),
    .j       (j),
    .k       (k),
    .db_lvl  (db_lvl),
    .cmd_cnt (cmd_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (j === 1'b1) j_pulses++;
    if (k === 1'b1) k_pulses++;
    if (j === 1'b1 && k === 1'b1) jk_pulses++;
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int first_j;
    int nj;
    int nk;
    rst = 1'b0; en = 1'b1;
    btn_set = 1'b1; btn_clr = 1'b1; btn_tgl = 1'b1;
    tick(3);
    n_checks++;
    if (j !== 1'b0 || k !== 1'b0) begin
      n_fail++; $display("FAIL reset_jk: j=%b k=%b required 0 0", j, k);
    end
    n_checks++;
    if (cmd_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: cmd_cnt=%0d required 0", cmd_cnt);
    end
    n_checks++;
    if (db_lvl !== 3'b000) begin
      n_fail++; $display("FAIL reset_db: db_lvl=%b required 000", db_lvl);
    end
    rst = 1'b1; btn_clr = 1'b0; btn_tgl = 1'b0;
    first_j = 0; nj = 0; nk = 0;
    for (int n = 1; n <= 30; n++) begin
      tick(1);
      if (j === 1'b1) begin
        nj++;
        if (first_j == 0) first_j = n;
      end
      if (k === 1'b1) nk++;
      if (n == 19) begin
        n_checks++;
        if (cmd_cnt !== 8'd1) begin
          n_fail++; $display("FAIL reset_rel_cnt_edge19: cmd_cnt=%0d required 1", cmd_cnt);
        end
      end
    end
    n_checks++;
    if (first_j != 19) begin
      n_fail++; $display("FAIL reset_rel_latency: first j at edge %0d required 19", first_j);
    end
    n_checks++;
    if (nj != 1 || nk != 0) begin
      n_fail++; $display("FAIL reset_rel_pulses: j cycles=%0d k cycles=%0d required 1 0", nj, nk);
    end
    btn_set = 1'b0;
    tick(25);
    n_checks++;
    if (cmd_cnt !== 8'd1 || db_lvl !== 3'b000) begin
      n_fail++; $display("FAIL reset_release_idle: cmd_cnt=%0d db_lvl=%b required 1 000", cmd_cnt, db_lvl);
    end
  endtask

  task automatic test_glitch;
    int  k0;
    logic [7:0] c0;
    bit  seen_db;
    k0 = k_pulses; c0 = cmd_cnt; seen_db = 1'b0;
    btn_clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (db_lvl[1] === 1'b1) seen_db = 1'b1;
    end
    btn_clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (db_lvl[1] === 1'b1) seen_db = 1'b1;
    end
    n_checks++;
    if (seen_db) begin
      n_fail++; $display("FAIL glitch_db: db_lvl[1] rose, required to stay 0");
    end
    n_checks++;
    if (k_pulses - k0 != 0) begin
      n_fail++; $display("FAIL glitch_k: k pulses=%0d required 0", k_pulses - k0);
    end
    n_checks++;
    if (cmd_cnt !== c0) begin
      n_fail++; $display("FAIL glitch_cnt: cmd_cnt=%0d required %0d", cmd_cnt, c0);
    end
  endtask

  task automatic test_simultaneous;
    int j0, k0, b0;
    logic [7:0] c0;
    j0 = j_pulses; k0 = k_pulses; b0 = jk_pulses; c0 = cmd_cnt;
    btn_set = 1'b1; btn_clr = 1'b1;
    tick(40);
    n_checks++;
    if (jk_pulses - b0 != 1 || j_pulses - j0 != 1 || k_pulses - k0 != 1) begin
      n_fail++;
      $display("FAIL simul_pulses: jk=%0d j=%0d k=%0d required 1 1 1",
               jk_pulses - b0, j_pulses - j0, k_pulses - k0);
    end
    n_checks++;
    if (cmd_cnt !== c0 + 8'd1) begin
      n_fail++; $display("FAIL simul_cnt: cmd_cnt=%0d required %0d", cmd_cnt, c0 + 8'd1);
    end
    n_checks++;
    if (db_lvl !== 3'b011) begin
      n_fail++; $display("FAIL simul_db: db_lvl=%b required 011", db_lvl);
    end
    btn_set = 1'b0; btn_clr = 1'b0;
    tick(25);
  endtask

  task automatic test_enable;
    int j0, k0, b0;
    logic [7:0] c0;
    j0 = j_pulses; k0 = k_pulses; c0 = cmd_cnt;
    en = 1'b0; btn_tgl = 1'b1;
    tick(25);
    en = 1'b1;
    tick(10);
    n_checks++;
    if (j_pulses - j0 != 0 || k_pulses - k0 != 0 || cmd_cnt !== c0) begin
      n_fail++;
      $display("FAIL en_gate: j=%0d k=%0d cmd_cnt=%0d required 0 0 %0d",
               j_pulses - j0, k_pulses - k0, cmd_cnt, c0);
    end
    n_checks++;
    if (db_lvl[2] !== 1'b1) begin
      n_fail++; $display("FAIL en_db: db_lvl[2]=%b required 1", db_lvl[2]);
    end
    btn_tgl = 1'b0;
    tick(25);
    b0 = jk_pulses; j0 = j_pulses; k0 = k_pulses;
    btn_tgl = 1'b1;
    tick(25);
    n_checks++;
    if (jk_pulses - b0 != 1 || j_pulses - j0 != 1 || k_pulses - k0 != 1) begin
      n_fail++;
      $display("FAIL en_repress: jk=%0d j=%0d k=%0d required 1 1 1",
               jk_pulses - b0, j_pulses - j0, k_pulses - k0);
    end
    n_checks++;
    if (cmd_cnt !== c0 + 8'd1) begin
      n_fail++; $display("FAIL en_cnt: cmd_cnt=%0d required %0d", cmd_cnt, c0 + 8'd1);
    end
    btn_tgl = 1'b0;
    tick(25);
  endtask

  task automatic test_wrap;
    int j0, k0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    j0 = j_pulses; k0 = k_pulses;
    for (int p = 1; p <= 256; p++) begin
      btn_set = 1'b1;
      tick(20);
      btn_set = 1'b0;
      tick(20);
      if (p == 255) begin
        n_checks++;
        if (cmd_cnt !== 8'd255) begin
          n_fail++; $display("FAIL wrap_255: cmd_cnt=%0d required 255", cmd_cnt);
        end
      end
    end
    n_checks++;
    if (cmd_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_zero: cmd_cnt=%0d required 0", cmd_cnt);
    end
    n_checks++;
    if (j_pulses - j0 != 256 || k_pulses - k0 != 0) begin
      n_fail++; $display("FAIL wrap_pulses: j=%0d k=%0d required 256 0",
                         j_pulses - j0, k_pulses - k0);
    end
  endtask

  task automatic test_reset_mid_debounce;
    int first_jk;
    int nj, nk;
    btn_tgl = 1'b1;
    tick(10);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    first_jk = 0; nj = 0; nk = 0;
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      if (j === 1'b1) nj++;
      if (k === 1'b1) nk++;
      if (j === 1'b1 && k === 1'b1 && first_jk == 0) first_jk = n;
    end
    n_checks++;
    if (first_jk != 19) begin
      n_fail++; $display("FAIL rstmid_latency: first j&k at edge %0d required 19", first_jk);
    end
    n_checks++;
    if (nj != 1 || nk != 1) begin
      n_fail++; $display("FAIL rstmid_pulses: j=%0d k=%0d required 1 1", nj, nk);
    end
    n_checks++;
    if (cmd_cnt !== 8'd1) begin
      n_fail++; $display("FAIL rstmid_cnt: cmd_cnt=%0d required 1", cmd_cnt);
    end
    btn_tgl = 1'b0;
    tick(25);
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_simultaneous;
    test_enable;
    test_wrap;
    test_reset_mid_debounce;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
